// File: rtl/split_order_ctrl.sv
// split_order_ctrl: keeps packets leaving a two-branch splitter in push order,
// granting the forwarder or releasing rejected buffers strictly at the FIFO head.
module split_order_ctrl #(
  parameter int QUEUE_DEPTH = 8,
  parameter int QADDR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_done,
  input  logic                 push_choice,
  input  logic                 acc_left,
  input  logic                 acc_right,
  input  logic                 rej_left,
  input  logic                 rej_right,
  input  logic                 fwd_done,
  output logic                 fwd_valid,
  output logic                 fwd_sel,
  output logic                 rel_left,
  output logic                 rel_right,
  output logic [QADDR_WIDTH:0] count,
  output logic                 overflow,
  output logic                 busy
);
  localparam logic [1:0] IDLE = 2'd0, ARB = 2'd1, FWD = 2'd2;
  localparam logic [QADDR_WIDTH:0] FULL = (QADDR_WIDTH+1)'(QUEUE_DEPTH);
  logic [1:0]             r_state, w_next;
  logic [QUEUE_DEPTH-1:0] r_mem;
  logic [QADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic w_head, w_acc, w_rej, w_grant, w_pop, w_push;
  assign w_head  = r_mem[r_rptr];
  assign w_acc   = w_head ? acc_right : acc_left;
  assign w_rej   = w_head ? rej_right : rej_left;
  assign w_grant = (r_state == ARB) && w_acc;
  assign w_pop   = ((r_state == ARB) && !w_acc && w_rej) || ((r_state == FWD) && fwd_done);
  // a full queue still takes a push when the head leaves on the same edge
  assign w_push  = push_done && ((count != FULL) || w_pop);
  always_comb begin
    w_next = (r_state == IDLE) ? ((count != '0) ? ARB : IDLE) :
             (r_state == ARB)  ? (w_grant ? FWD : (w_pop ? IDLE : ARB)) :
             (r_state == FWD)  ? (fwd_done ? IDLE : FWD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_choice;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      fwd_valid <= 1'b0;
      fwd_sel   <= 1'b0;
      rel_left  <= 1'b0;
      rel_right <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wptr    <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr    <= w_pop ? r_rptr + 1'b1 : r_rptr;
      count     <= count + (QADDR_WIDTH+1)'(w_push) - (QADDR_WIDTH+1)'(w_pop);
      overflow  <= overflow | (push_done & ~w_push);
      fwd_valid <= (w_next == FWD);
      fwd_sel   <= w_grant ? w_head : fwd_sel;
      rel_left  <= w_pop & ~w_head;
      rel_right <= w_pop & w_head;
      busy      <= (w_next != IDLE);
    end
  end
endmodule

// File: tb/tb_split_order_ctrl.sv
// tb_split_order_ctrl: directed scenarios for split_order_ctrl with hand-computed expectations.
module tb_split_order_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push_done = 1'b0, push_choice = 1'b0;
  logic acc_left = 1'b0, acc_right = 1'b0, rej_left = 1'b0, rej_right = 1'b0;
  logic fwd_done = 1'b0;
  logic fwd_valid, fwd_sel, rel_left, rel_right, overflow, busy;
  logic [3:0] count;
  int checks = 0, failures = 0;

  split_order_ctrl #(.QUEUE_DEPTH(8), .QADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .push_done(push_done), .push_choice(push_choice),
    .acc_left(acc_left), .acc_right(acc_right), .rej_left(rej_left), .rej_right(rej_right),
    .fwd_done(fwd_done), .fwd_valid(fwd_valid), .fwd_sel(fwd_sel),
    .rel_left(rel_left), .rel_right(rel_right), .count(count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b);
    push_choice = b;
    push_done = 1'b1;
    tick;
    push_done = 1'b0;
  endtask

  // Plays the forwarder (fwd_done two cycles after each grant) and records grants and releases.
  task automatic serve(input int n, output int gc, output logic [7:0] gs,
                       output int rc, output logic [7:0] rs, output int bad);
    int w;
    logic cur;
    gc = 0; rc = 0; gs = '0; rs = '0; bad = 0; w = 0; cur = 1'b0;
    for (int c = 0; c < 200 && rc < n; c++) begin
      if (rel_left && rel_right) bad++;
      if ((rel_left || rel_right) && rc < 8) begin rs[rc] = rel_right; rc++; end
      if (fwd_valid) begin
        w++;
        if (w == 1 && gc < 8) begin gs[gc] = fwd_sel; cur = fwd_sel; gc++; end
        else if (fwd_sel !== cur) bad++;
      end else w = 0;
      fwd_done = (w == 2);
      if (rc < n) tick;
    end
    fwd_done = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({fwd_valid, fwd_sel, rel_left, rel_right, count, overflow, busy} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b",
               {fwd_valid, fwd_sel, rel_left, rel_right, count, overflow, busy}, 10'b0);
    end
    push_done = 1'b1;
    tick;
    tick;
    push_done = 1'b0;
    checks++;
    if (count !== 4'd0) begin failures++; $display("FAIL push_in_reset count=%0d want=0", count); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_order;
    int gc, rc, bad;
    logic [7:0] gs, rs;
    acc_left = 1'b1; acc_right = 1'b1;
    push(1'b0); push(1'b1); push(1'b0);
    serve(3, gc, gs, rc, rs, bad);
    checks++;
    if (gc !== 3 || gs[2:0] !== 3'b010) begin
      failures++; $display("FAIL order_grants got n=%0d seq=%b want n=3 seq=010", gc, gs[2:0]);
    end
    checks++;
    if (rc !== 3 || rs[2:0] !== 3'b010) begin
      failures++; $display("FAIL order_releases got n=%0d seq=%b want n=3 seq=010", rc, rs[2:0]);
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL order_protocol violations=%0d want=0", bad); end
    checks++;
    if (count !== 4'd0) begin failures++; $display("FAIL order_count got=%0d want=0", count); end
    acc_left = 1'b0; acc_right = 1'b0;
    tick;
  endtask

  task automatic test_head_blocking;
    int gc, rc, bad, early;
    logic [7:0] gs, rs;
    acc_left = 1'b1;
    push(1'b1); push(1'b0);
    early = 0;
    for (int i = 0; i < 10; i++) begin
      if (fwd_valid || rel_left || rel_right) early++;
      tick;
    end
    checks++;
    if (early !== 0) begin failures++; $display("FAIL head_block early_events=%0d want=0", early); end
    checks++;
    if (count !== 4'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL head_block_state count=%0d busy=%b want count=2 busy=1", count, busy);
    end
    acc_right = 1'b1;
    serve(2, gc, gs, rc, rs, bad);
    checks++;
    if (gc !== 2 || gs[1:0] !== 2'b01 || rc !== 2 || rs[1:0] !== 2'b01 || bad !== 0) begin
      failures++;
      $display("FAIL head_block_seq grants=%0d/%b rels=%0d/%b bad=%0d want 2/01 2/01 0",
               gc, gs[1:0], rc, rs[1:0], bad);
    end
    acc_left = 1'b0; acc_right = 1'b0;
    tick;
  endtask

  task automatic test_reject;
    rej_left = 1'b1;
    push(1'b0);
    checks++;
    if (count !== 4'd1 || rel_left !== 1'b0) begin
      failures++; $display("FAIL reject_e0 count=%0d rel_left=%b want 1 0", count, rel_left);
    end
    tick;
    checks++;
    if (rel_left !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL reject_e1 rel_left=%b busy=%b want 0 1", rel_left, busy);
    end
    tick;
    checks++;
    if (rel_left !== 1'b1 || rel_right !== 1'b0 || fwd_valid !== 1'b0 || count !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse rel_l=%b rel_r=%b fwd_valid=%b count=%0d busy=%b want 1 0 0 0 0",
               rel_left, rel_right, fwd_valid, count, busy);
    end
    tick;
    checks++;
    if (rel_left !== 1'b0 || fwd_valid !== 1'b0) begin
      failures++; $display("FAIL reject_one_cycle rel_left=%b fwd_valid=%b want 0 0", rel_left, fwd_valid);
    end
    rej_left = 1'b0;
  endtask

  task automatic test_non_head_and_priority;
    int gc, rc, bad, ev;
    logic [7:0] gs, rs;
    acc_left = 1'b1; rej_left = 1'b1;
    push(1'b1);
    ev = 0;
    for (int i = 0; i < 6; i++) begin
      if (fwd_valid || rel_left || rel_right) ev++;
      tick;
    end
    checks++;
    if (ev !== 0) begin failures++; $display("FAIL non_head_ignored events=%0d want=0", ev); end
    acc_left = 1'b0; rej_left = 1'b0;
    acc_right = 1'b1; rej_right = 1'b1;
    serve(1, gc, gs, rc, rs, bad);
    checks++;
    if (gc !== 1 || gs[0] !== 1'b1 || rc !== 1 || rs[0] !== 1'b1 || bad !== 0) begin
      failures++;
      $display("FAIL acc_priority grants=%0d sel=%b rels=%0d side=%b bad=%0d want 1 1 1 1 0",
               gc, gs[0], rc, rs[0], bad);
    end
    acc_right = 1'b0; rej_right = 1'b0;
    tick;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) push(1'b0);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      failures++; $display("FAIL fill count=%0d overflow=%b want 8 0", count, overflow);
    end
    push(1'b0);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      failures++; $display("FAIL overflow count=%0d overflow=%b want 8 1", count, overflow);
    end
    rej_left = 1'b1;
    push(1'b1);
    rej_left = 1'b0;
    checks++;
    if (count !== 4'd8 || rel_left !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL push_with_pop count=%0d rel_left=%b overflow=%b want 8 1 1", count, rel_left, overflow);
    end
    fwd_done = 1'b1;
    tick;
    fwd_done = 1'b0;
    checks++;
    if (count !== 4'd8 || fwd_valid !== 1'b0) begin
      failures++; $display("FAIL stray_fwd_done count=%0d fwd_valid=%b want 8 0", count, fwd_valid);
    end
  endtask

  task automatic test_reset_mid_fwd;
    int gc, rc, bad, n, ev;
    logic [7:0] gs, rs;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if (overflow !== 1'b0 || count !== 4'd0) begin
      failures++; $display("FAIL reset_clears overflow=%b count=%0d want 0 0", overflow, count);
    end
    acc_left = 1'b1;
    push(1'b0); push(1'b0);
    n = 0;
    while (!fwd_valid && n < 20) begin tick; n++; end
    checks++;
    if (fwd_valid !== 1'b1) begin failures++; $display("FAIL grant_timeout fwd_valid=%b want 1", fwd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fwd_valid !== 1'b0 || count !== 4'd0 || busy !== 1'b0 || rel_left !== 1'b0) begin
      failures++;
      $display("FAIL async_reset fwd_valid=%b count=%0d busy=%b rel_left=%b want 0 0 0 0",
               fwd_valid, count, busy, rel_left);
    end
    tick;
    rst_n = 1'b1;
    ev = 0;
    for (int i = 0; i < 4; i++) begin
      if (rel_left || rel_right || fwd_valid) ev++;
      tick;
    end
    checks++;
    if (ev !== 0) begin failures++; $display("FAIL post_reset_quiet events=%0d want=0", ev); end
    push(1'b0);
    serve(1, gc, gs, rc, rs, bad);
    checks++;
    if (gc !== 1 || gs[0] !== 1'b0 || rc !== 1 || rs[0] !== 1'b0 || bad !== 0 || count !== 4'd0) begin
      failures++;
      $display("FAIL after_reset grants=%0d sel=%b rels=%0d side=%b bad=%0d count=%0d want 1 0 1 0 0 0",
               gc, gs[0], rc, rs[0], bad, count);
    end
    acc_left = 1'b0;
  endtask

  initial begin
    test_reset;
    test_order;
    test_head_blocking;
    test_reject;
    test_non_head_and_priority;
    test_overflow;
    test_reset_mid_fwd;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/split_order_ctrl.md
SPLIT_ORDER_CTRL -- requirements
Module: split_order_ctrl

Interface
REQ-001 Parameter QUEUE_DEPTH, default 8: number of outstanding packet-order entries; SHALL be a power of 2, minimum 2.
REQ-002 Parameter QADDR_WIDTH, default 3: log2(QUEUE_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 push_done  input  1  one-cycle pulse: upstream splitter finished writing a packet.
REQ-006 push_choice  input  1  branch the packet went to, sampled with push_done (0 left, 1 right).
REQ-007 acc_left / acc_right  input  1 each  level: that branch's CPU holds an accepted packet awaiting forwarding.
REQ-008 rej_left / rej_right  input  1 each  level: that branch's CPU holds a rejected packet awaiting release.
REQ-009 fwd_done  input  1  one-cycle pulse: forwarder finished reading the granted packet.
REQ-010 fwd_valid  output  1  forwarder grant active.
REQ-011 fwd_sel  output  1  branch the forwarder reads (0 left, 1 right).
REQ-012 rel_left / rel_right  output  1 each  one-cycle pulse: release that CPU's packet buffer.
REQ-013 count  output  QADDR_WIDTH+1  occupied queue entries.
REQ-014 overflow  output  1  sticky: a push was dropped.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Block SHALL hold a FIFO of push_choice bits, QUEUE_DEPTH entries, read/write pointers wrapping modulo QUEUE_DEPTH.
REQ-017 push_done with count<QUEUE_DEPTH SHALL write push_choice at the write pointer and increment count on that edge.
REQ-018 push_done with count==QUEUE_DEPTH SHALL be dropped and set overflow, unless a pop occurs on the same edge, in which case the push is accepted.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 FSM states: IDLE, ARB, FWD; head = FIFO entry at read pointer.
REQ-021 IDLE: count!=0 -> ARB next edge; otherwise stay.
REQ-022 ARB, head branch b: acc_b=1 -> FWD, fwd_valid=1, fwd_sel=b from the next edge; acc_b=0 and rej_b=1 -> rel_b pulses one cycle, pop, -> IDLE; both 0 -> stay ARB.
REQ-023 acc_b SHALL take priority over rej_b when both are high.
REQ-024 Inputs of the non-head branch SHALL be ignored; order of release always equals order of push.
REQ-025 FWD: fwd_valid and fwd_sel held stable until fwd_done; on fwd_done: fwd_valid=0, rel_b pulses one cycle, pop, -> IDLE on the same edge.
REQ-026 fwd_done outside FWD SHALL be ignored.
REQ-027 All outputs SHALL be registered; minimum turnaround per packet is 3 cycles (IDLE, ARB, FWD).
REQ-028 rel_left and rel_right SHALL never be high in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, pointers 0, count 0, fwd_valid 0, fwd_sel 0, rel_left/rel_right 0, overflow 0, busy 0.
REQ-030 Reset mid-FWD SHALL drop the grant with no rel pulse; queued entries are discarded.
REQ-031 push_done during reset SHALL be ignored.

Verification
REQ-032 Push L,R,L; acc_left/acc_right held high; fwd_done 2 cycles after each grant -> fwd_sel sequence 0,1,0, rel pulses L,R,L, count returns 0.
REQ-033 Push R then L; acc_left high first, acc_right high 10 cycles later -> no grant until acc_right; fwd_sel=1 granted first.
REQ-034 Push L with rej_left=1, acc_left=0 -> rel_left pulse 2 cycles after count becomes 1, fwd_valid never asserted.
REQ-035 Push 9 packets at depth 8, no pops -> count=8, overflow=1; then push coincident with pop -> accepted, count stays 8.
REQ-036 rst_n low during FWD -> fwd_valid=0, count=0 same cycle; rel pulses absent; subsequent push L handled normally.
